eva_ahb_slv_regfile: RTL and testbench
======================================

// Module: eva_ahb_slv_regfile
// PURPOSE
//  AHB-Lite slave register file: the responder end of the EVA AHB master port.
//  Holds NREG 32-bit registers; index 0 is a read-only ID register.
//  Inserts a programmable number of wait states per transfer.
//  Returns a two-cycle ERROR response for illegal accesses.
//  Sits behind the AHB decoder and is used as the DUT-side target for EVA AHB traffic.
// PARAMETERS
//  NREG      16             number of 32-bit registers (2..1024); offset = index*4
//  WAIT_CYC  0              wait states inserted per legal transfer (0..15)
//  ID_VAL    32'hE7A0_0001  read value of register 0
// PORTS
//  hclk        in   1   clock; all logic on rising edge
//  hrest       in   1   reset, asynchronous, active-high
//  hsel        in   1   slave select from decoder
//  htrans      in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite      in   1   1 = write
//  haddr       in   32  byte address; only haddr[11:0] decoded
//  hsize       in   2   transfer size; only 2'b10 (word) legal
//  hwdata      in   32  write data, valid in data phase
//  hready_in   in   1   bus HREADY (muxed); address phase valid only when high
//  hready_out  out  1   slave ready
//  hresp       out  2   00 OKAY, 01 ERROR
//  hrdata      out  32  read data
// BEHAVIOUR
//  Reset (async, while hrest=1):
//   - all registers 0; state IDLE
//   - hready_out=1, hresp=00, hrdata=0
//   - reset mid-transfer abandons it; no write commits.
//  Accept rule:
//   - accept = hsel & htrans[1] & hready_in
//   - on accept, capture hwrite, idx = haddr[11:2], and illegal flag.
//   - illegal = (hsize!=2'b10) | (haddr[1:0]!=0) | (idx>=NREG)
//   - IDLE/BUSY or hsel=0: no capture; next cycle zero-wait OKAY.
//  FSM states:
//   - IDLE:
//     - hready_out=1, hresp=00.
//     - accept & ~illegal & WAIT_CYC==0 -> DATA.
//     - accept & ~illegal & WAIT_CYC>0 -> WAIT (cnt=WAIT_CYC-1).
//     - accept & illegal -> ERR1.
//   - WAIT:
//     - hready_out=0, hresp=00.
//     - cnt==0 -> DATA, else cnt--.
//   - DATA:
//     - hready_out=1, hresp=00; completes the data phase.
//     - write with idx!=0: reg[idx]<=hwdata at the closing edge.
//     - write with idx==0: ignored, OKAY.
//     - read: hrdata = (idx==0 ? ID_VAL : reg[idx]), driven combinationally from captured idx.
//     - next state: same accept decode as IDLE (pipelined back-to-back), else IDLE.
//   - ERR1:
//     - hready_out=0, hresp=01 -> ERR2.
//   - ERR2:
//     - hready_out=1, hresp=01; no register change.
//     - next state: same accept decode as IDLE.
//  Read data and error responses:
//   - hrdata=0 outside a DATA read cycle.
//   - A master may abort with IDLE in ERR2; the accept decode sees htrans=00 -> IDLE.
//  Latency:
//   - read/write completes WAIT_CYC+1 cycles after address phase.
//   - back-to-back NONSEQ sustains 1 transfer per WAIT_CYC+1 cycles.
//  Hazards:
//   - write then read, same idx, back-to-back: the read returns the new value.
//   - Write commits at the end of its DATA phase, before the read's DATA cycle.
// TESTING
//  T1 reset: assert hrest mid-WAIT -> hready_out=1, hresp=00, all regs read 0 afterwards.
//  T2 write/read: W idx3=0xDEADBEEF then R idx3, WAIT_CYC=0.
//     -> OKAY each cycle, hrdata=0xDEADBEEF in cycle 2 after read address phase.
//  T3 ID: R 0x000 -> 0xE7A00001; W 0x000=0x1234 then R 0x000 -> still 0xE7A00001, hresp=00.
//  T4 error: R 0x040 (idx16, NREG=16), hsize=01, and addr 0x006.
//     -> each gives hready_out 0 then 1 with hresp=01 both cycles; regs unchanged.
//  T5 wait states: WAIT_CYC=2, W idx5=0xA5A5A5A5.
//     -> hready_out low exactly 2 cycles, write visible on the following read.
//  T6 pipeline: NONSEQ W idx1, W idx2, R idx1, R idx2 back-to-back, WAIT_CYC=0.
//     -> 4 consecutive OKAY completions, correct data, no bubbles.

Source files
------------

// File: rtl/eva_ahb_slv_regfile_if.sv
// AHB-Lite slave-side bus bundle for the EVA register file target.
// The master modport is the bus side (decoder/mux plus initiator);
// the slave modport is the register file.
interface eva_ahb_slv_regfile_if;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [1:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/eva_ahb_slv_regfile.sv
// AHB-Lite slave register file. NREG word registers, index 0 is a
// read-only ID. Legal transfers take WAIT_CYC wait states; illegal ones
// (non-word size, misaligned, out of range) get a two-cycle ERROR.
module eva_ahb_slv_regfile #(
  parameter int unsigned NREG     = 16,
  parameter int unsigned WAIT_CYC = 0,
  parameter logic [31:0] ID_VAL   = 32'hE7A0_0001
) (
  input  logic                 hclk,
  input  logic                 hrest,
  eva_ahb_slv_regfile_if.slave bus
);

  localparam int unsigned IDXW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [10:0] NREG_W   = 11'(NREG);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  state_t          entry_s;
  logic [3:0]      cnt_r;
  logic [3:0]      cnt_nxt_s;
  logic            write_r;
  logic [IDXW-1:0] idx_r;
  logic [9:0]      addr_idx_s;
  logic            accept_s;
  logic            illegal_s;
  logic            take_s;
  logic            ready_s;
  logic [1:0]      resp_s;
  logic [31:0]     rdata_s;
  logic [31:0]     regs_r [NREG];
  logic            unused_s;

  // Only the low 12 address bits are decoded.
  assign unused_s   = ^bus.haddr[31:12];
  assign addr_idx_s = bus.haddr[11:2];
  assign accept_s   = bus.hsel & bus.htrans[1] & bus.hready_in;
  assign illegal_s  = (bus.hsize != 2'b10) | (bus.haddr[1:0] != 2'b00) |
                      ({1'b0, addr_idx_s} >= NREG_W);
  // A new address phase is only taken in states that end with hready high.
  assign take_s     = accept_s &
                      ((state_r == ST_IDLE) | (state_r == ST_DATA) | (state_r == ST_ERR2));

  // Accept decode shared by every state that can start a new transfer.
  always_comb begin
    entry_s = ST_IDLE;
    if (accept_s) begin
      if (illegal_s) begin
        entry_s = ST_ERR1;
      end else if (WAIT_CYC == 0) begin
        entry_s = ST_DATA;
      end else begin
        entry_s = ST_WAIT;
      end
    end else begin
      entry_s = ST_IDLE;
    end
  end

  // Next-state, wait counter and handshake outputs.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ready_s     = 1'b1;
    resp_s      = RESP_OKAY;
    case (state_r)
      ST_IDLE, ST_DATA: begin
        state_nxt_s = entry_s;
        if (entry_s == ST_WAIT) begin
          cnt_nxt_s = CNT_INIT;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_WAIT: begin
        ready_s = 1'b0;
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_DATA;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_ERR1: begin
        ready_s     = 1'b0;
        resp_s      = RESP_ERROR;
        state_nxt_s = ST_ERR2;
      end
      ST_ERR2: begin
        resp_s      = RESP_ERROR;
        state_nxt_s = entry_s;
        if (entry_s == ST_WAIT) begin
          cnt_nxt_s = CNT_INIT;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and captured address-phase attributes.
  always_ff @(posedge hclk or posedge hrest) begin
    if (hrest) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      write_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (take_s) begin
        write_r <= bus.hwrite;
        idx_r   <= addr_idx_s[IDXW-1:0];
      end
    end
  end

  // Register array; a write commits on the edge that closes its data phase.
  always_ff @(posedge hclk or posedge hrest) begin
    if (hrest) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if ((state_r == ST_DATA) && write_r && (idx_r != {IDXW{1'b0}})) begin
      regs_r[idx_r] <= bus.hwdata;
    end
  end

  // Read data is only driven during a read data cycle, zero otherwise.
  always_comb begin
    rdata_s = 32'd0;
    if ((state_r == ST_DATA) && !write_r) begin
      if (idx_r == {IDXW{1'b0}}) begin
        rdata_s = ID_VAL;
      end else begin
        rdata_s = regs_r[idx_r];
      end
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.hready_out = ready_s;
  assign bus.hresp      = resp_s;
  assign bus.hrdata     = rdata_s;

endmodule

// File: tb/tb_eva_ahb_slv_regfile.sv
// Directed bench for eva_ahb_slv_regfile: one zero-wait instance and one
// two-wait instance share the stimulus; sel_dut steers hsel and the
// observed outputs.
module tb_eva_ahb_slv_regfile;
  logic hclk = 1'b0;
  logic hrest = 1'b1;
  always #5 hclk = ~hclk;

  eva_ahb_slv_regfile_if bus0 ();
  eva_ahb_slv_regfile_if bus2 ();

  logic        sel_dut;
  logic        hsel_v;
  logic [1:0]  htrans_v;
  logic        hwrite_v;
  logic [31:0] haddr_v;
  logic [1:0]  hsize_v;
  logic [31:0] hwdata_v;

  assign bus0.hsel      = hsel_v & ~sel_dut;
  assign bus2.hsel      = hsel_v & sel_dut;
  assign bus0.htrans    = htrans_v;
  assign bus2.htrans    = htrans_v;
  assign bus0.hwrite    = hwrite_v;
  assign bus2.hwrite    = hwrite_v;
  assign bus0.haddr     = haddr_v;
  assign bus2.haddr     = haddr_v;
  assign bus0.hsize     = hsize_v;
  assign bus2.hsize     = hsize_v;
  assign bus0.hwdata    = hwdata_v;
  assign bus2.hwdata    = hwdata_v;
  assign bus0.hready_in = bus0.hready_out;
  assign bus2.hready_in = bus2.hready_out;

  wire        rdy_m   = sel_dut ? bus2.hready_out : bus0.hready_out;
  wire [1:0]  resp_m  = sel_dut ? bus2.hresp      : bus0.hresp;
  wire [31:0] rdata_m = sel_dut ? bus2.hrdata     : bus0.hrdata;

  eva_ahb_slv_regfile #(.NREG(16), .WAIT_CYC(0), .ID_VAL(32'hE7A0_0001)) dut0 (
    .hclk (hclk),
    .hrest(hrest),
    .bus  (bus0)
  );

  eva_ahb_slv_regfile #(.NREG(16), .WAIT_CYC(2), .ID_VAL(32'hE7A0_0001)) dut2 (
    .hclk (hclk),
    .hrest(hrest),
    .bus  (bus2)
  );

  int errs = 0;
  int checks = 0;

  // One NONSEQ transfer starting at a negedge; returns at the negedge of the
  // completing cycle so a following call forms a pipelined address phase.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic [1:0] resp_done, output logic [1:0] resp_wait,
                      output int waits);
    hsel_v = 1'b1; htrans_v = 2'b10; hwrite_v = w; haddr_v = a; hsize_v = sz;
    @(posedge hclk); @(negedge hclk);
    hsel_v = 1'b0; htrans_v = 2'b00; hwdata_v = wd;
    waits = 0; resp_wait = 2'b00; rd = 32'hFFFF_FFFF; resp_done = 2'b11;
    for (int i = 0; i < 40; i++) begin
      if (rdy_m === 1'b1) begin
        rd = rdata_m; resp_done = resp_m;
        break;
      end
      if (waits == 0) resp_wait = resp_m;
      waits++;
      @(posedge hclk); @(negedge hclk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic [1:0] rs, rw; int wt;
    #1;
    checks++; if ({bus0.hready_out, bus0.hresp, bus0.hrdata} !== {1'b1, 2'b00, 32'd0}) begin
      errs++; $display("FAIL reset_dut0: got rdy=%b resp=%b rdata=%h want 1 00 0", bus0.hready_out, bus0.hresp, bus0.hrdata); end
    checks++; if ({bus2.hready_out, bus2.hresp, bus2.hrdata} !== {1'b1, 2'b00, 32'd0}) begin
      errs++; $display("FAIL reset_dut2: got rdy=%b resp=%b rdata=%h want 1 00 0", bus2.hready_out, bus2.hresp, bus2.hrdata); end
    @(negedge hclk); hrest = 1'b0;
    @(negedge hclk);
    sel_dut = 1'b1;
    xfer(1'b1, 32'h10, 2'b10, 32'h1111_1111, rd, rs, rw, wt);
    xfer(1'b0, 32'h10, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if (rd !== 32'h1111_1111) begin
      errs++; $display("FAIL pre_reset_rd: got %h want 11111111", rd); end
    // start a write, then reset while it waits
    hsel_v = 1'b1; htrans_v = 2'b10; hwrite_v = 1'b1; haddr_v = 32'h10; hsize_v = 2'b10;
    @(posedge hclk); @(negedge hclk);
    hsel_v = 1'b0; htrans_v = 2'b00; hwdata_v = 32'h2222_2222;
    checks++; if (rdy_m !== 1'b0) begin
      errs++; $display("FAIL mid_wait_rdy: got %b want 0", rdy_m); end
    #2 hrest = 1'b1;
    #1;
    checks++; if ({rdy_m, resp_m, rdata_m} !== {1'b1, 2'b00, 32'd0}) begin
      errs++; $display("FAIL reset_mid_wait: got rdy=%b resp=%b rdata=%h want 1 00 0", rdy_m, resp_m, rdata_m); end
    @(negedge hclk); hrest = 1'b0;
    @(negedge hclk);
    for (int k = 1; k < 16; k++) begin
      xfer(1'b0, 32'(k * 4), 2'b10, 32'h0, rd, rs, rw, wt);
      checks++; if ({rs, rd} !== {2'b00, 32'd0}) begin
        errs++; $display("FAIL post_reset_reg%0d: got resp=%b rdata=%h want 00 0", k, rs, rd); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic [1:0] rs, rw; int wt;
    sel_dut = 1'b0;
    xfer(1'b1, 32'h0C, 2'b10, 32'hDEAD_BEEF, rd, rs, rw, wt);
    checks++; if ({rs, wt} !== {2'b00, 32'd0}) begin
      errs++; $display("FAIL wr_idx3: got resp=%b waits=%0d want 00 0", rs, wt); end
    xfer(1'b0, 32'h0C, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if ({rs, wt, rd} !== {2'b00, 32'd0, 32'hDEAD_BEEF}) begin
      errs++; $display("FAIL rd_idx3: got resp=%b waits=%0d rdata=%h want 00 0 deadbeef", rs, wt, rd); end
  endtask

  task automatic test_id();
    logic [31:0] rd; logic [1:0] rs, rw; int wt;
    sel_dut = 1'b0;
    xfer(1'b0, 32'h0, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if ({rs, rd} !== {2'b00, 32'hE7A0_0001}) begin
      errs++; $display("FAIL id_rd: got resp=%b rdata=%h want 00 e7a00001", rs, rd); end
    xfer(1'b1, 32'h0, 2'b10, 32'h0000_1234, rd, rs, rw, wt);
    checks++; if (rs !== 2'b00) begin
      errs++; $display("FAIL id_wr_resp: got %b want 00", rs); end
    xfer(1'b0, 32'h0, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if ({rs, rd} !== {2'b00, 32'hE7A0_0001}) begin
      errs++; $display("FAIL id_rd_after_wr: got resp=%b rdata=%h want 00 e7a00001", rs, rd); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic [1:0] rs, rw; int wt;
    logic        ew [3];
    logic [31:0] ea [3];
    logic [1:0]  es [3];
    ew[0] = 1'b0; ea[0] = 32'h40; es[0] = 2'b10;
    ew[1] = 1'b1; ea[1] = 32'h0C; es[1] = 2'b01;
    ew[2] = 1'b1; ea[2] = 32'h06; es[2] = 2'b10;
    sel_dut = 1'b0;
    for (int k = 0; k < 3; k++) begin
      xfer(ew[k], ea[k], es[k], 32'h0000_0BAD, rd, rs, rw, wt);
      checks++; if ({wt, rw, rs} !== {32'd1, 2'b01, 2'b01}) begin
        errs++; $display("FAIL err_case%0d: got waits=%0d resp_low=%b resp_high=%b want 1 01 01", k, wt, rw, rs); end
    end
    checks++; if (rd !== 32'd0) begin
      errs++; $display("FAIL err_rdata: got %h want 0", rd); end
    // BUSY and deselected NONSEQ must not start a transfer
    hsel_v = 1'b1; htrans_v = 2'b01; hwrite_v = 1'b1; haddr_v = 32'h18; hsize_v = 2'b10;
    @(posedge hclk); @(negedge hclk);
    hsel_v = 1'b0; htrans_v = 2'b10; hwdata_v = 32'h0000_CAFE;
    checks++; if ({rdy_m, resp_m} !== {1'b1, 2'b00}) begin
      errs++; $display("FAIL busy_nocap: got rdy=%b resp=%b want 1 00", rdy_m, resp_m); end
    @(posedge hclk); @(negedge hclk);
    htrans_v = 2'b00;
    checks++; if ({rdy_m, resp_m} !== {1'b1, 2'b00}) begin
      errs++; $display("FAIL nosel_nocap: got rdy=%b resp=%b want 1 00", rdy_m, resp_m); end
    xfer(1'b0, 32'h18, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if (rd !== 32'd0) begin
      errs++; $display("FAIL nocap_reg6: got %h want 0", rd); end
    xfer(1'b0, 32'h0C, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if (rd !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL err_keep_reg3: got %h want deadbeef", rd); end
    xfer(1'b0, 32'h04, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if (rd !== 32'd0) begin
      errs++; $display("FAIL err_keep_reg1: got %h want 0", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic [1:0] rs, rw; int wt;
    sel_dut = 1'b1;
    xfer(1'b1, 32'h14, 2'b10, 32'hA5A5_A5A5, rd, rs, rw, wt);
    checks++; if ({wt, rw, rs} !== {32'd2, 2'b00, 2'b00}) begin
      errs++; $display("FAIL wait_wr: got waits=%0d resp_low=%b resp=%b want 2 00 00", wt, rw, rs); end
    xfer(1'b0, 32'h14, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if ({wt, rs, rd} !== {32'd2, 2'b00, 32'hA5A5_A5A5}) begin
      errs++; $display("FAIL wait_rd: got waits=%0d resp=%b rdata=%h want 2 00 a5a5a5a5", wt, rs, rd); end
    xfer(1'b0, 32'h40, 2'b10, 32'h0, rd, rs, rw, wt);
    checks++; if ({wt, rw, rs} !== {32'd1, 2'b01, 2'b01}) begin
      errs++; $display("FAIL wait_err: got waits=%0d resp_low=%b resp=%b want 1 01 01", wt, rw, rs); end
  endtask

  task automatic test_back_to_back();
    logic        pw [4];
    logic [31:0] pa [4];
    logic [31:0] pd [4];
    logic [31:0] px [4];
    pw[0] = 1'b1; pa[0] = 32'h04; pd[0] = 32'h1111_0001; px[0] = 32'd0;
    pw[1] = 1'b1; pa[1] = 32'h08; pd[1] = 32'h2222_0002; px[1] = 32'd0;
    pw[2] = 1'b0; pa[2] = 32'h04; pd[2] = 32'd0;         px[2] = 32'h1111_0001;
    pw[3] = 1'b0; pa[3] = 32'h08; pd[3] = 32'd0;         px[3] = 32'h2222_0002;
    sel_dut = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        checks++; if ({rdy_m, resp_m, rdata_m} !== {1'b1, 2'b00, px[k-1]}) begin
          errs++; $display("FAIL b2b_xfer%0d: got rdy=%b resp=%b rdata=%h want 1 00 %h",
                           k - 1, rdy_m, resp_m, rdata_m, px[k-1]); end
        hwdata_v = pd[k-1];
      end
      if (k < 4) begin
        hsel_v = 1'b1; htrans_v = 2'b10; hwrite_v = pw[k]; haddr_v = pa[k]; hsize_v = 2'b10;
      end else begin
        hsel_v = 1'b0; htrans_v = 2'b00;
      end
      @(posedge hclk); @(negedge hclk);
    end
  endtask

  initial begin
    sel_dut = 1'b0; hsel_v = 1'b0; htrans_v = 2'b00; hwrite_v = 1'b0;
    haddr_v = 32'd0; hsize_v = 2'b10; hwdata_v = 32'd0;
    test_reset();
    test_write_read();
    test_id();
    test_error();
    test_wait_states();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
